mpc_cfg_sequencer: RTL and testbench
====================================

Name: mpc_cfg_sequencer

Overview:
- Upstream control stage for the multi-project-chip IO selector.
- Owns the 4-bit `configuration` word that drives the vertical selectors and the top line selector.
- Accepts new configurations through a valid/ready handshake and changes them glitch-safely: it blanks every pad output-enable, switches the configuration, lets the selectors settle, then releases the pads.
- Also gates the 38 selected output-enables (east 14, west 14, north 10) before they reach the pads.

Parameters:
- CFG_W, 4: configuration width. Only 4 is supported.
- BLANK_CYCLES, 16: cycles that all pad OEs are held low before the switch. Must be >= 1.
- SETTLE_CYCLES, 8: cycles that all pad OEs are held low after the switch. Must be >= 1.
- RESET_CFG, 4'd0: configuration value loaded on reset. Must be legal under LEGAL_MASK.
- LEGAL_MASK, 16'h000F: bit n = 1 means configuration value n is legal.

Ports:
- wb_clk_i, input, 1: the single clock.
- wb_rst_i, input, 1: reset, synchronous, active-high.
- cfg_valid, input, 1: a requested configuration is present.
- cfg_data, input, 4: requested configuration value.
- cfg_ready, output, 1: sequencer can accept a request.
- configuration, output, 4: registered configuration driven to the selectors.
- io_blank, output, 1: registered; 1 forces all pad OEs low.
- busy, output, 1: 1 whenever the state is not IDLE.
- cfg_done, output, 1: one-cycle pulse when a request completes.
- cfg_err, output, 1: one-cycle pulse when an illegal request is rejected.
- oe_in, input, 38: selected OEs, ordered {north[9:0], west[13:0], east[13:0]}.
- oe_out, output, 38: pad OEs, equal to oe_in & {38{~io_blank}}. Combinational from the registered io_blank.

Behaviour:
- States: IDLE, DRAIN, SWITCH, SETTLE. One down-counter, width clog2(max(BLANK_CYCLES, SETTLE_CYCLES) + 1).
- Reset (wb_rst_i = 1 at a clock edge), every register updates on that edge:
  - state <= SETTLE, counter <= SETTLE_CYCLES.
  - configuration <= RESET_CFG, io_blank <= 1.
  - cfg_done <= 0, cfg_err <= 0, pending register cleared, post-reset flag set.
  - Outputs while in reset: cfg_ready = 0, busy = 1.
- Reset mid-operation: any in-flight request is abandoned and its pending value discarded. No done or err pulse is generated for it.
- cfg_ready = 1 only in IDLE and only when wb_rst_i = 0. A transfer occurs on a cycle with cfg_valid & cfg_ready.
- Transfer in IDLE, call it cycle T:
  - cfg_data illegal (LEGAL_MASK[cfg_data] = 0): stay in IDLE, cfg_err = 1 in cycle T+1, configuration unchanged, no blanking.
  - cfg_data == configuration: stay in IDLE, cfg_done = 1 in cycle T+1, no blanking.
  - Otherwise: pending <= cfg_data, state <= DRAIN, counter <= BLANK_CYCLES, io_blank <= 1.
- DRAIN: counter decrements each cycle. When the counter reaches 1, state <= SWITCH. io_blank = 1 for BLANK_CYCLES cycles, T+1 through T+B.
- SWITCH, cycle T+B+1, one cycle: configuration <= pending, counter <= SETTLE_CYCLES, state <= SETTLE. The new configuration is visible from cycle T+B+2.
- SETTLE: counter decrements each cycle. When the counter reaches 1, state <= IDLE and io_blank <= 0.
  - If the post-reset flag is clear, cfg_done <= 1; if it is set, the flag is cleared and no done pulse is generated.
  - Result: IDLE, io_blank = 0, cfg_ready = 1 and cfg_done = 1 all occur in cycle T+B+S+2.
- configuration changes only in SWITCH or reset, so it never changes while io_blank = 0.
- cfg_valid while not ready: ignored. The requester must hold cfg_valid and cfg_data until a transfer occurs.
- cfg_data changing while cfg_valid is high and ready is low: no effect. Only the value at the transfer cycle is sampled.
- Back-to-back requests: the next transfer can occur in the same cycle as cfg_done, because ready is high in that cycle.
- cfg_done and cfg_err are never high in the same cycle. Each is a pulse of exactly one cycle.

Test Plan:
- Reset exit, defaults: wb_rst_i held for 3 cycles, then low. Required:
  - configuration = 0 and io_blank = 1 for 8 cycles after deassertion.
  - cfg_ready = 1 in the 9th cycle, with no cfg_done.
  - oe_out = 0 while blanked, then equal to oe_in = 38'h3F_FFFF_FFFF.
- Legal switch 0 -> 2, accepted at cycle T. Required:
  - io_blank = 1 from T+1 to T+25.
  - configuration = 0 through T+17, then 2 from T+18.
  - cfg_done pulse, io_blank = 0 and cfg_ready = 1 at T+26.
- Illegal request cfg_data = 4'd9 with LEGAL_MASK = 16'h000F. Required: cfg_err = 1 at T+1 only, configuration stays 2, io_blank stays 0, cfg_done stays 0.
- Same-value request cfg_data = current value 2. Required: cfg_done at T+1, io_blank never asserted, busy stays 0.
- Reset mid-DRAIN: request 2 -> 3, then assert wb_rst_i at T+5. Required:
  - configuration = 0 and io_blank = 1 after that edge.
  - After deassertion, 8 cycles of blanking, then IDLE.
  - No cfg_done; value 3 never appears on configuration.
- Held valid while busy: cfg_valid held high with cfg_data = 1 during a 0 -> 3 switch. Required:
  - Second transfer occurs at the cfg_done cycle of the first (T+26).
  - configuration = 1 from T+44, with the second cfg_done at T+52.

Source files
------------

// File: rtl/mpc_cfg_sequencer.sv
// mpc_cfg_sequencer: upstream control for the multi-project-chip IO selector.
// Holds the configuration word and switches it glitch-safely: blank all pad
// output-enables, drain, switch, let the selectors settle, then release pads.
module mpc_cfg_sequencer #(
  parameter int                      CFG_W         = 4,
  parameter int                      BLANK_CYCLES  = 16,
  parameter int                      SETTLE_CYCLES = 8,
  parameter logic [CFG_W-1:0]        RESET_CFG     = 4'd0,
  parameter logic [(1<<CFG_W)-1:0]   LEGAL_MASK    = 16'h000F
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] configuration,
  output logic             io_blank,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err,
  input  logic [37:0]      oe_in,
  output logic [37:0]      oe_out
);

  localparam int MAX_CNT = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] BLANK_LD  = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CFG_W-1:0] pending_q, pending_d;
  logic             blank_q, blank_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             post_rst_q, post_rst_d;

  logic             xfer;

  // Handshake: requests are only taken in IDLE and never while reset is held.
  assign cfg_ready     = (state_q == IDLE) && !wb_rst_i;
  assign busy          = (state_q != IDLE) || wb_rst_i;
  assign xfer          = cfg_valid && cfg_ready;
  assign configuration = cfg_q;
  assign io_blank      = blank_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign oe_out        = oe_in & {38{~blank_q}};

  // Next-state logic: the pulses default low so each lasts exactly one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_d      = cfg_q;
    pending_d  = pending_q;
    blank_d    = blank_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    post_rst_d = post_rst_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (!LEGAL_MASK[cfg_data]) begin
            err_d = 1'b1;
          end else if (cfg_data == cfg_q) begin
            done_d = 1'b1;
          end else begin
            pending_d = cfg_data;
            state_d   = DRAIN;
            cnt_d     = BLANK_LD;
            blank_d   = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = SWITCH;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SWITCH: begin
        cfg_d   = pending_q;
        cnt_d   = SETTLE_LD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          blank_d = 1'b0;
          if (post_rst_q) begin
            post_rst_d = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LD;
        blank_d = 1'b1;
      end
    endcase
  end

  // State registers; reset drops any in-flight request and re-runs the settle phase.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= SETTLE;
      cnt_q      <= SETTLE_LD;
      cfg_q      <= RESET_CFG;
      pending_q  <= '0;
      blank_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_q      <= cfg_d;
      pending_q  <= pending_d;
      blank_q    <= blank_d;
      done_q     <= done_d;
      err_q      <= err_d;
      post_rst_q <= post_rst_d;
    end
  end

endmodule

// File: tb/tb_mpc_cfg_sequencer.sv
// tb_mpc_cfg_sequencer: directed scenarios for the configuration sequencer
// with hand-computed, cycle-by-cycle expectations.
module tb_mpc_cfg_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [3:0]  cfg_data;
  logic        cfg_ready;
  logic [3:0]  configuration;
  logic        io_blank;
  logic        busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [37:0] oe_in;
  logic [37:0] oe_out;

  int errors = 0;
  int checks = 0;

  mpc_cfg_sequencer dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .cfg_valid     (cfg_valid),
    .cfg_data      (cfg_data),
    .cfg_ready     (cfg_ready),
    .configuration (configuration),
    .io_blank      (io_blank),
    .busy          (busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .oe_in         (oe_in),
    .oe_out        (oe_out)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held 3 cycles, then 8 blanked settle cycles, then ready with no done.
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cfg_ready !== 1'b0 || busy !== 1'b1 || io_blank !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc%0d ready/busy/blank got %b%b%b want 011", i, cfg_ready, busy, io_blank);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (configuration !== 4'd0 || io_blank !== 1'b1 || oe_out !== 38'd0 ||
          cfg_ready !== 1'b0 || cfg_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_settle cyc%0d cfg=%h blank=%b oe=%h ready=%b done=%b want cfg=0 blank=1 oe=0 ready=0 done=0",
                 k, configuration, io_blank, oe_out, cfg_ready, cfg_done);
      end
      tick();
    end
    checks++;
    if (cfg_ready !== 1'b1 || cfg_done !== 1'b0 || io_blank !== 1'b0 ||
        oe_out !== 38'h3F_FFFF_FFFF || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_exit ready=%b done=%b blank=%b oe=%h busy=%b want 1 0 0 3fffffffff 0",
               cfg_ready, cfg_done, io_blank, oe_out, busy);
    end
  endtask

  // Legal switch 0 -> 2: blank T+1..T+25, new cfg from T+18, done at T+26.
  task automatic test_legal_switch();
    logic       exp_blank;
    logic [3:0] exp_cfg;
    logic       exp_last;
    cfg_valid = 1'b1;
    cfg_data  = 4'd2;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL legal_accept ready got %b want 1", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
    cfg_data  = 4'd0;
    for (int k = 1; k <= 27; k++) begin
      exp_blank = (k <= 25);
      exp_cfg   = (k <= 17) ? 4'd0 : 4'd2;
      exp_last  = (k == 26);
      checks++;
      if (io_blank !== exp_blank || configuration !== exp_cfg || cfg_done !== exp_last ||
          cfg_ready !== (k >= 26) || cfg_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL legal_switch T+%0d blank=%b cfg=%h done=%b ready=%b err=%b want blank=%b cfg=%h done=%b ready=%b err=0",
                 k, io_blank, configuration, cfg_done, cfg_ready, cfg_err, exp_blank, exp_cfg, exp_last, (k >= 26));
      end
      if (k < 27) tick();
    end
  endtask

  // Illegal value 9 is rejected with a single err pulse and no side effects.
  task automatic test_illegal();
    cfg_valid = 1'b1;
    cfg_data  = 4'd9;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || cfg_done !== 1'b0 || configuration !== 4'd2 || io_blank !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_pulse err=%b done=%b cfg=%h blank=%b want 1 0 2 0",
               cfg_err, cfg_done, configuration, io_blank);
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0 || configuration !== 4'd2 || io_blank !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_after err=%b cfg=%h blank=%b busy=%b want 0 2 0 0",
               cfg_err, configuration, io_blank, busy);
    end
  endtask

  // Re-requesting the current value completes at once without blanking.
  task automatic test_same_value();
    cfg_valid = 1'b1;
    cfg_data  = 4'd2;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_done !== 1'b1 || cfg_err !== 1'b0 || io_blank !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_value_pulse done=%b err=%b blank=%b busy=%b want 1 0 0 0",
               cfg_done, cfg_err, io_blank, busy);
    end
    tick();
    checks++;
    if (cfg_done !== 1'b0 || io_blank !== 1'b0 || busy !== 1'b0 || configuration !== 4'd2) begin
      errors++;
      $display("[TB] FAIL same_value_after done=%b blank=%b busy=%b cfg=%h want 0 0 0 2",
               cfg_done, io_blank, busy, configuration);
    end
  endtask

  // Reset during DRAIN abandons the 2 -> 3 request: value 3 never appears, no done.
  task automatic test_reset_mid_drain();
    cfg_valid = 1'b1;
    cfg_data  = 4'd3;
    tick();
    cfg_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (configuration !== 4'd2 || io_blank !== 1'b1) begin
        errors++;
        $display("[TB] FAIL mid_drain T+%0d cfg=%h blank=%b want 2 1", k, configuration, io_blank);
      end
      if (k < 5) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (configuration !== 4'd0 || io_blank !== 1'b1 || cfg_done !== 1'b0 || cfg_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL drain_reset_settle cyc%0d cfg=%h blank=%b done=%b ready=%b want 0 1 0 0",
                 k, configuration, io_blank, cfg_done, cfg_ready);
      end
      tick();
    end
    checks++;
    if (cfg_ready !== 1'b1 || io_blank !== 1'b0 || cfg_done !== 1'b0 || configuration !== 4'd0) begin
      errors++;
      $display("[TB] FAIL drain_reset_exit ready=%b blank=%b done=%b cfg=%h want 1 0 0 0",
               cfg_ready, io_blank, cfg_done, configuration);
    end
  endtask

  // Valid held through a 0 -> 3 switch with data changed to 1: second transfer at T+26.
  task automatic test_back_to_back();
    logic [3:0] exp_cfg;
    logic       exp_blank;
    logic       exp_done;
    cfg_valid = 1'b1;
    cfg_data  = 4'd3;
    tick();
    cfg_data  = 4'd1;
    for (int k = 1; k <= 53; k++) begin
      exp_cfg   = (k <= 17) ? 4'd0 : ((k <= 43) ? 4'd3 : 4'd1);
      exp_blank = (k <= 25) || (k >= 27 && k <= 51);
      exp_done  = (k == 26) || (k == 52);
      checks++;
      if (configuration !== exp_cfg || io_blank !== exp_blank || cfg_done !== exp_done || cfg_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL back_to_back T+%0d cfg=%h blank=%b done=%b err=%b want cfg=%h blank=%b done=%b err=0",
                 k, configuration, io_blank, cfg_done, cfg_err, exp_cfg, exp_blank, exp_done);
      end
      if (k == 52) cfg_valid = 1'b0;
      if (k < 53) tick();
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Scenario sequence.
  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 4'd0;
    oe_in     = 38'h3F_FFFF_FFFF;
    test_reset();
    test_legal_switch();
    test_illegal();
    test_same_value();
    test_reset_mid_drain();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
